// File: rtl/mul_pipe.sv
// Pipelined signed/unsigned multiply stage for MUL/MULH/MULHSU/MULHU with valid/ready flow control.
// Define MUL_PIPE_PROD_REG_EN to add a product register (S2) between the multiplier core and the sign/select logic.
module mul_pipe #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   in_op,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_result
);

  // Two's-complement magnitude of v when it is treated as signed and negative.
  function automatic logic [W-1:0] magnitude(input logic [W-1:0] v, input logic is_neg);
    logic [W-1:0] m;
    if (is_neg) begin
      m = -v;
    end else begin
      m = v;
    end
    return m;
  endfunction

  // Re-apply the sign to the full product, then pick the half the op asks for.
  function automatic logic [W-1:0] select_result(input logic [2*W-1:0] prod,
                                                 input logic neg, input logic hi);
    logic [2*W-1:0] p;
    if (neg) begin
      p = -prod;
    end else begin
      p = prod;
    end
    if (hi) begin
      return p[2*W-1:W];
    end else begin
      return p[W-1:0];
    end
  endfunction

  logic         a_sgn_s;
  logic         b_sgn_s;
  logic         s1_ready_s;
  logic         so_ready_s;
  logic         accept_s;

  logic         s1_valid_r;
  logic [W-1:0] s1_a_r;
  logic [W-1:0] s1_b_r;
  logic         s1_neg_r;
  logic         s1_hi_r;

  logic [2*W-1:0] core_prod_s;
  logic           feed_valid_s;
  logic [2*W-1:0] feed_prod_s;
  logic           feed_neg_s;
  logic           feed_hi_s;

  logic         out_valid_r;
  logic [W-1:0] out_result_r;

  // Sign treatment: MUL is unsigned, MULHSU signs only a, MULH signs both.
  always_comb begin
    a_sgn_s = 1'b0;
    b_sgn_s = 1'b0;
    case (in_op)
      2'b01: begin
        a_sgn_s = in_a[W-1];
        b_sgn_s = in_b[W-1];
      end
      2'b10: begin
        a_sgn_s = in_a[W-1];
        b_sgn_s = 1'b0;
      end
      default: begin
        a_sgn_s = 1'b0;
        b_sgn_s = 1'b0;
      end
    endcase
  end

  assign so_ready_s = !out_valid_r || out_ready;
  assign in_ready   = s1_ready_s && !flush;
  assign accept_s   = in_valid && in_ready;

  // S1 operand register: magnitudes, result sign and half select.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s1_a_r     <= {W{1'b0}};
      s1_b_r     <= {W{1'b0}};
      s1_neg_r   <= 1'b0;
      s1_hi_r    <= 1'b0;
    end else if (flush) begin
      s1_valid_r <= 1'b0;
    end else if (s1_ready_s) begin
      s1_valid_r <= accept_s;
      if (accept_s) begin
        s1_a_r   <= magnitude(in_a, a_sgn_s);
        s1_b_r   <= magnitude(in_b, b_sgn_s);
        s1_neg_r <= a_sgn_s ^ b_sgn_s;
        s1_hi_r  <= (in_op != 2'b00);
      end
    end
  end

  // Unsigned W x W -> 2W multiplier core.
  assign core_prod_s = {{W{1'b0}}, s1_a_r} * {{W{1'b0}}, s1_b_r};

`ifdef MUL_PIPE_PROD_REG_EN
  logic           s2_ready_s;
  logic           s2_valid_r;
  logic [2*W-1:0] s2_prod_r;
  logic           s2_neg_r;
  logic           s2_hi_r;

  assign s2_ready_s = !s2_valid_r || so_ready_s;
  assign s1_ready_s = !s1_valid_r || s2_ready_s;

  // S2 product register splits the core from the negate/select path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_r <= 1'b0;
      s2_prod_r  <= {(2*W){1'b0}};
      s2_neg_r   <= 1'b0;
      s2_hi_r    <= 1'b0;
    end else if (flush) begin
      s2_valid_r <= 1'b0;
    end else if (s2_ready_s) begin
      s2_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        s2_prod_r <= core_prod_s;
        s2_neg_r  <= s1_neg_r;
        s2_hi_r   <= s1_hi_r;
      end
    end
  end

  assign feed_valid_s = s2_valid_r;
  assign feed_prod_s  = s2_prod_r;
  assign feed_neg_s   = s2_neg_r;
  assign feed_hi_s    = s2_hi_r;
`else
  assign s1_ready_s   = !s1_valid_r || so_ready_s;
  assign feed_valid_s = s1_valid_r;
  assign feed_prod_s  = core_prod_s;
  assign feed_neg_s   = s1_neg_r;
  assign feed_hi_s    = s1_hi_r;
`endif

  // SO output register; result only changes when a new op is loaded, so it holds under stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r  <= 1'b0;
      out_result_r <= {W{1'b0}};
    end else if (flush) begin
      out_valid_r <= 1'b0;
    end else if (so_ready_s) begin
      out_valid_r <= feed_valid_s;
      if (feed_valid_s) begin
        out_result_r <= select_result(feed_prod_s, feed_neg_s, feed_hi_s);
      end
    end
  end

  assign out_valid  = out_valid_r;
  assign out_result = out_result_r;

endmodule

// File: tb/tb_mul_pipe.sv
// Scoreboard bench for mul_pipe: driver pushes expected results, a negedge monitor pops on each output handshake.
module tb_mul_pipe;

`ifdef MUL_PIPE_PROD_REG_EN
  localparam int DEPTH = 3;
`else
  localparam int DEPTH = 2;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;

  int n_vec  = 0;
  int n_miss = 0;
  logic [31:0] exp_q[$];

  mul_pipe #(.W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every output handshake must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_result: got 0x%08h, expected no output", out_result);
      end else begin
        check("result", out_result, exp_q.pop_front());
      end
    end
  end

  // Issue one op (called just after a rising edge); expectation recorded when it is accepted.
  task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] exp);
    int t;
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      check("send_timeout", 32'(in_ready), 32'd1);
    end else begin
      exp_q.push_back(exp);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 50) begin
      @(posedge clk);
      t++;
    end
    #1;
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int idx;
    int first_low;
    int k;
    logic acc;

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_op = 2'b00; in_a = 32'd0; in_b = 32'd0;
    @(negedge clk);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_result", out_result, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Directed function vectors.
    send(2'b00, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB);
    send(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
    send(2'b01, 32'h80000000, 32'h80000000, 32'h40000000);
    send(2'b01, 32'h80000000, 32'd1,        32'hFFFFFFFF);
    send(2'b01, 32'd0,        32'h80000000, 32'h00000000);
    send(2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
    send(2'b10, 32'd2,        32'h80000000, 32'h00000001);
    send(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000);
    send(2'b00, 32'h80000000, 32'd2,        32'h00000000);
    drain();

    // Back-to-back MULs against a 6-cycle output stall.
    idx = 0;
    first_low = -1;
    for (int cyc = 0; cyc < 20 && (idx < 4 || cyc < 10); cyc++) begin
      out_ready = (cyc >= 6);
      in_valid  = (idx < 4);
      in_op     = 2'b00;
      in_a      = 32'(idx + 1);
      in_b      = 32'(idx + 1);
      @(negedge clk);
      if (cyc >= 6 && cyc < 10) check("stall_release_valid", 32'(out_valid), 32'd1);
      if (first_low < 0 && !in_ready && cyc < 6) first_low = idx;
      acc = in_valid && in_ready;
      if (acc) exp_q.push_back(32'((idx + 1) * (idx + 1)));
      @(posedge clk);
      #1;
      if (acc) idx++;
    end
    in_valid = 1'b0;
    check("stall_accepts", 32'(first_low), 32'(DEPTH));
    drain();

    // Fill the pipe under stall, then flush while an op is presented.
    out_ready = 1'b0;
    for (k = 0; k < 8; k++) begin
      in_valid = 1'b1; in_op = 2'b00; in_a = 32'(11 + k); in_b = 32'd3;
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (!acc) break;
    end
    in_a = 32'd9; in_b = 32'd9; flush = 1'b1;
    @(negedge clk);
    check("flush_in_ready_low", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("flush_out_valid", 32'(out_valid), 32'd0);
    check("flush_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // MUL 5x6 after flush at nominal latency.
    in_valid = 1'b1; in_op = 2'b00; in_a = 32'd5; in_b = 32'd6;
    @(negedge clk);
    check("lat_in_ready", 32'(in_ready), 32'd1);
    exp_q.push_back(32'd30);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    k = 0;
    @(negedge clk);
    while (!out_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("latency_edges", 32'(k), 32'(DEPTH - 1));
    drain();

    // Asynchronous reset with two ops in flight.
    out_ready = 1'b0;
    send(2'b00, 32'd3, 32'd5, 32'd15);
    send(2'b00, 32'd6, 32'd7, 32'd42);
    k = 0;
    while (!out_valid && k < 10) begin
      @(negedge clk);
      k++;
    end
    check("rst_pre_valid", 32'(out_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("rst_async_valid", 32'(out_valid), 32'd0);
    check("rst_async_result", out_result, 32'd0);
    exp_q.delete();
    out_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    send(2'b11, 32'h12345678, 32'h00000010, 32'h00000001);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
